data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares one single-port data memory between NUM_CORES processor cores in the multicore top level.
- Each core's dataMemAddr / ProcessorDataOut / DataMemWrEn path becomes a req/ack transaction.
- A round-robin FSM serialises the transactions onto the memory port and returns read data to the granted core.
- Sits between the core array and the data memory instance.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..16).
- ADDR_WIDTH, 12, data memory address width.
- DATA_WIDTH, 12, data word width (equals core REG_WIDTH).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- core_req  input  NUM_CORES  per-core request; held high until that core's ack.
- core_wrEn  input  NUM_CORES  per-core op: 1 = write, 0 = read; stable while req is high.
- core_addr  input  NUM_CORES*ADDR_WIDTH  packed addresses; core i in bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- core_wdata  input  NUM_CORES*DATA_WIDTH  packed write data; same packing rule.
- core_ack  output  NUM_CORES  one-hot, single-cycle completion pulse.
- core_rdata  output  DATA_WIDTH  read data broadcast to all cores; valid only with the ack of a read.
- mem_addr  output  ADDR_WIDTH  memory address (registered).
- mem_wdata  output  DATA_WIDTH  memory write data (registered).
- mem_wrEn  output  1  memory write enable (registered).
- mem_rdata  input  DATA_WIDTH  memory read data, valid one cycle after mem_addr.
- busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- Reset values: state=IDLE, ptr=0, core_ack=0, core_rdata=0, mem_addr=0, mem_wdata=0, mem_wrEn=0, busy=0, grant index=0, mask=0.
- States: IDLE, SERVE, RWAIT, ACK.
- IDLE:
  - eligible = core_req & ~mask.
  - If eligible is nonzero, pick g = first set bit searching ptr, ptr+1, ..., wrapping mod NUM_CORES.
  - Register g; load mem_addr and mem_wdata from core g; mem_wrEn = core_wrEn[g]; ptr = (g+1) mod NUM_CORES; go to SERVE.
  - If eligible is zero, stay in IDLE with mem_wrEn=0.
- SERVE:
  - Memory sees the address, plus the write when mem_wrEn=1.
  - Write: next state ACK.
  - Read: next state RWAIT.
  - mem_wrEn returns to 0 on exit, so it is high for exactly one cycle per write.
- RWAIT: capture mem_rdata into core_rdata; go to ACK.
- ACK: core_ack[g]=1 for exactly one cycle; mask = one-hot(g); go to IDLE.
- Mask:
  - mask applies only in the first IDLE cycle after ACK, then clears.
  - This covers a core still dropping req after its ack.
  - A core must deassert req in the cycle after ack; a new request may follow from the next cycle.
- Latency, from req visible in IDLE to ack:
  - Write: 2 cycles (IDLE edge -> SERVE -> ACK).
  - Read: 3 cycles (IDLE -> SERVE -> RWAIT -> ACK).
- core_rdata holds its last read value until the next RWAIT; it is not cleared on write.
- Simultaneous requests: exactly one grant per transaction.
  - With all cores requesting continuously, grants rotate 0, 1, 2, 3, 0, ...
  - No starvation: any held req is served within NUM_CORES transactions.
- ptr wraps from NUM_CORES-1 to 0.
- Reset mid-operation:
  - All state returns to reset values at that edge; no ack is issued.
  - A write presented in SERVE during the reset edge is committed by memory (it samples the same edge). Cores must reissue aborted requests.
- A req deasserted before ack (protocol violation) does not affect an in-flight transaction.

Decomposition:
- Package details gains:
  - arb_state_t enum {IDLE, SERVE, RWAIT, ACK}.
  - A localparam for the default NUM_CORES.
- Sub-module rr_picker: combinational rotating priority picker.
  - Inputs: eligible vector, ptr.
  - Outputs: grant index, valid.
  - Instantiated once inside data_mem_arbiter.

Test Plan:
- Single write:
  - Stimulus: reset, then core 2 req, wrEn=1, addr=0x01A, wdata=0xABC.
  - Response: mem_wrEn=1 with mem_addr=0x01A, mem_wdata=0xABC one cycle later; core_ack=0100 the next cycle; busy high for 2 cycles.
- Single read:
  - Stimulus: memory holds 0x5A5 at 0x003; core 1 req read addr=0x003.
  - Response: core_ack=0010 three cycles after req, with core_rdata=0x5A5; mem_wrEn stays 0.
- Round-robin:
  - Stimulus: cores 0..3 all request writes continuously, each re-requesting right after its ack.
  - Response: ack order 0, 1, 2, 3, 0, 1; no core is acked twice in a row.
- Priority after wrap:
  - Stimulus: ptr=3 after serving core 2; cores 0 and 3 request simultaneously.
  - Response: core 3 is granted first, then core 0; ptr returns to 1.
- Mask:
  - Stimulus: core 0 keeps req high one cycle after ack while core 1 also requests.
  - Response: core 1 is granted; core 0 is not re-granted in that cycle.
- Reset mid-read:
  - Stimulus: assert rst during RWAIT of a core 3 read.
  - Response: next cycle state=IDLE, core_ack=0, core_rdata=0, busy=0; no ack is issued for core 3.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and defaults for the multicore data memory arbiter.
package data_mem_arbiter_pkg;

  localparam int DEFAULT_NUM_CORES  = 4;
  localparam int DEFAULT_ADDR_WIDTH = 12;
  localparam int DEFAULT_DATA_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    RWAIT = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  // Next round-robin position after idx, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Core-side request/ack bus plus the single memory port of the arbiter.
interface data_mem_arbiter_if
  import data_mem_arbiter_pkg::*;
#(
  parameter int NUM_CORES  = DEFAULT_NUM_CORES,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic [NUM_CORES-1:0]            core_req;
  logic [NUM_CORES-1:0]            core_wrEn;
  logic [NUM_CORES*ADDR_WIDTH-1:0] core_addr;
  logic [NUM_CORES*DATA_WIDTH-1:0] core_wdata;
  logic [NUM_CORES-1:0]            core_ack;
  logic [DATA_WIDTH-1:0]           core_rdata;
  logic [ADDR_WIDTH-1:0]           mem_addr;
  logic [DATA_WIDTH-1:0]           mem_wdata;
  logic                            mem_wrEn;
  logic [DATA_WIDTH-1:0]           mem_rdata;
  logic                            busy;

  // Arbiter side: drives acks and the memory port.
  modport master (
    input  core_req, core_wrEn, core_addr, core_wdata, mem_rdata,
    output core_ack, core_rdata, mem_addr, mem_wdata, mem_wrEn, busy
  );

  // Environment side: the cores and the memory instance.
  modport slave (
    output core_req, core_wrEn, core_addr, core_wdata, mem_rdata,
    input  core_ack, core_rdata, mem_addr, mem_wdata, mem_wrEn, busy
  );

endinterface

// File: rtl/data_mem_arbiter_rr_picker.sv
// Combinational rotating-priority picker: first eligible index at or after i_ptr.
module data_mem_arbiter_rr_picker #(
  parameter int NUM_CORES = 4,
  parameter int PW        = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] i_eligible,
  input  logic [PW-1:0]        i_ptr,
  output logic [PW-1:0]        o_grant,
  output logic                 o_valid
);

  logic [PW:0]   w_sum;
  logic [PW-1:0] w_idx;
  logic          w_hit;
  logic          w_found;
  logic [PW-1:0] w_grant;

  // Walk ptr, ptr+1, ... modulo NUM_CORES and latch the first eligible index.
  always_comb begin
    w_sum   = '0;
    w_idx   = '0;
    w_hit   = 1'b0;
    w_found = 1'b0;
    w_grant = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      w_sum   = {1'b0, i_ptr} + (PW+1)'(k);
      w_idx   = (w_sum >= (PW+1)'(NUM_CORES)) ? PW'(w_sum - (PW+1)'(NUM_CORES))
                                              : w_sum[PW-1:0];
      w_hit   = i_eligible[w_idx] & ~w_found;
      w_grant = w_hit ? w_idx : w_grant;
      w_found = w_found | w_hit;
    end
  end

  assign o_grant = w_grant;
  assign o_valid = w_found;

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter serialising per-core req/ack transactions onto one
// single-port data memory; read data is broadcast with the requester's ack.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int NUM_CORES  = DEFAULT_NUM_CORES,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  data_mem_arbiter_if.master bus
);

  localparam int PW = $clog2(NUM_CORES);

  arb_state_t            r_state,     w_state_nxt;
  logic [PW-1:0]         r_ptr,       w_ptr_nxt;
  logic [PW-1:0]         r_grant,     w_grant_nxt;
  logic [NUM_CORES-1:0]  r_mask,      w_mask_nxt;
  logic [NUM_CORES-1:0]  r_ack,       w_ack_nxt;
  logic [DATA_WIDTH-1:0] r_rdata,     w_rdata_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr,  w_mem_addr_nxt;
  logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic                  r_mem_wrEn,  w_mem_wrEn_nxt;
  logic                  r_busy,      w_busy_nxt;

  logic [NUM_CORES-1:0]  w_eligible;
  logic [PW-1:0]         w_pick;
  logic                  w_pick_valid;

  function automatic logic [NUM_CORES-1:0] onehot(input logic [PW-1:0] idx);
    logic [NUM_CORES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // The just-acked core is hidden for one IDLE cycle while its req falls.
  assign w_eligible = bus.core_req & ~r_mask;

  data_mem_arbiter_rr_picker #(
    .NUM_CORES (NUM_CORES),
    .PW        (PW)
  ) u_picker (
    .i_eligible (w_eligible),
    .i_ptr      (r_ptr),
    .o_grant    (w_pick),
    .o_valid    (w_pick_valid)
  );

  // Next-state and next values of every registered output.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_grant_nxt     = r_grant;
    w_mask_nxt      = '0;
    w_rdata_nxt     = r_rdata;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_wrEn_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt     = SERVE;
          w_grant_nxt     = w_pick;
          w_ptr_nxt       = PW'(wrap_inc(int'(w_pick), NUM_CORES));
          w_mem_addr_nxt  = bus.core_addr[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
          w_mem_wdata_nxt = bus.core_wdata[w_pick*DATA_WIDTH +: DATA_WIDTH];
          w_mem_wrEn_nxt  = bus.core_wrEn[w_pick];
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SERVE: begin
        w_state_nxt = r_mem_wrEn ? ACK : RWAIT;
      end
      RWAIT: begin
        w_rdata_nxt = bus.mem_rdata;
        w_state_nxt = ACK;
      end
      ACK: begin
        w_mask_nxt  = onehot(r_grant);
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    w_ack_nxt  = (w_state_nxt == ACK) ? onehot(w_grant_nxt) : '0;
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // State register and registered outputs; reset overrides any transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_mask      <= '0;
      r_ack       <= '0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wrEn  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_grant     <= w_grant_nxt;
      r_mask      <= w_mask_nxt;
      r_ack       <= w_ack_nxt;
      r_rdata     <= w_rdata_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_wrEn  <= w_mem_wrEn_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign bus.core_ack   = r_ack;
  assign bus.core_rdata = r_rdata;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.mem_wrEn   = r_mem_wrEn;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: a transaction-level round-robin model
// predicts ack order, read data and memory writes; a monitor checks them.
module tb_data_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.NUM_CORES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  data_mem_arbiter #(.NUM_CORES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous single-port memory, read data valid one cycle after address.
  bit   [DW-1:0] mem [0:(1<<AW)-1];
  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (bus.mem_wrEn) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  typedef struct packed {logic wr; logic [AW-1:0] addr; logic [DW-1:0] data;} op_t;
  typedef struct {int core; logic [DW-1:0] rdata;} exp_ack_t;
  typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data;} exp_wr_t;

  op_t      ops [N][8];
  int       cnt [N];
  exp_ack_t ack_q[$];
  exp_wr_t  wr_q[$];

  bit [DW-1:0] model_mem [0:(1<<AW)-1];
  int          model_ptr = 0;
  logic [DW-1:0] last_rd = '0;

  int checks = 0, passes = 0;
  int cyc = 0, n_ack = 0, n_wr = 0, n_busy = 0, last_ack_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [N-1:0] oh(input int c);
    logic [N-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops the scoreboard whenever the DUT presents a write or an ack.
  initial forever begin
    @(negedge clk);
    if (bus.busy === 1'b1) n_busy++;
    if (bus.mem_wrEn === 1'b1) begin
      n_wr++;
      if (wr_q.size() == 0) check("unexpected_write", 32'(bus.mem_wrEn), 32'd0);
      else begin
        exp_wr_t w;
        w = wr_q.pop_front();
        check("mem_addr", 32'(bus.mem_addr), 32'(w.addr));
        check("mem_wdata", 32'(bus.mem_wdata), 32'(w.data));
      end
    end
    if (bus.core_ack !== '0) begin
      n_ack++;
      last_ack_cyc = cyc;
      if (ack_q.size() == 0) check("unexpected_ack", 32'(bus.core_ack), 32'd0);
      else begin
        exp_ack_t e;
        e = ack_q.pop_front();
        check("ack_core", 32'(bus.core_ack), 32'(oh(e.core)));
        check("ack_rdata", 32'(bus.core_rdata), 32'(e.rdata));
      end
    end
  end

  task automatic clear_ops();
    for (int c = 0; c < N; c++) cnt[c] = 0;
  endtask

  task automatic add_op(input int c, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ops[c][cnt[c]] = {wr, a, d};
    cnt[c]++;
  endtask

  // Reference: each grant goes to the first core, from ptr onward, with work left.
  task automatic predict();
    int pos [N];
    int rem, g;
    op_t op;
    rem = 0;
    for (int c = 0; c < N; c++) begin
      pos[c] = 0;
      rem += cnt[c];
    end
    while (rem > 0) begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && pos[(model_ptr + k) % N] < cnt[(model_ptr + k) % N]) g = (model_ptr + k) % N;
      op = ops[g][pos[g]];
      pos[g]++;
      rem--;
      if (op.wr) begin
        model_mem[op.addr] = op.data;
        wr_q.push_back('{op.addr, op.data});
      end else begin
        last_rd = model_mem[op.addr];
      end
      ack_q.push_back('{g, last_rd});
      model_ptr = (g + 1) % N;
    end
  endtask

  task automatic present(input int c, input int p);
    if (p < cnt[c]) begin
      bus.core_req[c]             = 1'b1;
      bus.core_wrEn[c]            = ops[c][p].wr;
      bus.core_addr[c*AW +: AW]   = ops[c][p].addr;
      bus.core_wdata[c*DW +: DW]  = ops[c][p].data;
    end else begin
      bus.core_req[c] = 1'b0;
    end
  endtask

  // Cores: hold req until ack, drop it, re-request two cycles later; the
  // 'hold' core keeps req one extra cycle after its ack.
  task automatic drive(input int hold);
    int pos [N];
    int cool [N];
    int rem, budget;
    bit drop_hold;
    predict();
    rem = 0;
    drop_hold = 1'b0;
    for (int c = 0; c < N; c++) begin
      pos[c] = 0;
      cool[c] = 0;
      rem += cnt[c];
      present(c, 0);
    end
    budget = 12 * rem + 20;
    while (rem > 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
      if (drop_hold) begin
        bus.core_req[hold] = 1'b0;
        drop_hold = 1'b0;
      end
      for (int c = 0; c < N; c++) begin
        if (bus.core_ack[c] === 1'b1) begin
          pos[c]++;
          rem--;
          cool[c] = 2;
          if (c == hold) drop_hold = 1'b1;
          else bus.core_req[c] = 1'b0;
        end else if (cool[c] > 0) begin
          cool[c]--;
          if (cool[c] == 0) present(c, pos[c]);
        end
      end
    end
    if (budget == 0) check("drive_timeout_pending", 32'(rem), 32'd0);
    if (drop_hold) bus.core_req[hold] = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    model_mem[a] = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  initial begin
    int c0, b0, w0, a0;
    rst = 1'b1;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    bus.core_req = '0; bus.core_wrEn = '0; bus.core_addr = '0; bus.core_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 32'(bus.core_ack), 32'd0);
    check("rst_rdata", 32'(bus.core_rdata), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_mem_wrEn", 32'(bus.mem_wrEn), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    settle(1);

    // Single write from core 2.
    clear_ops(); add_op(2, 1'b1, 12'h01A, 12'hABC);
    c0 = cyc; b0 = n_busy; w0 = n_wr;
    drive(-1); settle(3);
    check("wr_latency", 32'(last_ack_cyc - c0), 32'd2);
    check("wr_busy_cycles", 32'(n_busy - b0), 32'd2);
    check("wr_pulses", 32'(n_wr - w0), 32'd1);

    // Single read from core 1.
    preload(12'h003, 12'h5A5);
    clear_ops(); add_op(1, 1'b0, 12'h003, 12'h000);
    c0 = cyc; b0 = n_busy; w0 = n_wr;
    drive(-1); settle(3);
    check("rd_latency", 32'(last_ack_cyc - c0), 32'd3);
    check("rd_busy_cycles", 32'(n_busy - b0), 32'd3);
    check("rd_pulses", 32'(n_wr - w0), 32'd0);

    // Wrap priority: after core 2, cores 0 and 3 together -> 3 then 0; then ptr=1.
    clear_ops(); add_op(2, 1'b1, 12'h020, 12'h111); drive(-1); settle(2);
    clear_ops(); add_op(0, 1'b1, 12'h030, 12'h222); add_op(3, 1'b1, 12'h033, 12'h333);
    drive(-1); settle(2);
    clear_ops(); add_op(0, 1'b0, 12'h030, 12'h000); add_op(1, 1'b0, 12'h033, 12'h000);
    drive(-1); settle(2);

    // Mask: lone core 0 holding req past its ack must not be re-granted.
    clear_ops(); add_op(0, 1'b1, 12'h040, 12'h444);
    a0 = n_ack;
    drive(0); settle(6);
    check("mask_solo_acks", 32'(n_ack - a0), 32'd1);
    clear_ops(); add_op(3, 1'b0, 12'h040, 12'h000); drive(-1); settle(2);
    clear_ops(); add_op(0, 1'b1, 12'h050, 12'h555); add_op(1, 1'b0, 12'h050, 12'h000);
    a0 = n_ack;
    drive(0); settle(6);
    check("mask_pair_acks", 32'(n_ack - a0), 32'd2);

    // Reset during RWAIT of a core 3 read.
    preload(12'h007, 12'h3C3);
    a0 = n_ack;
    bus.core_req = 4'b1000; bus.core_wrEn = '0;
    bus.core_addr[3*AW +: AW] = 12'h007;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.core_req = '0;
    @(negedge clk);
    check("midrst_ack", 32'(bus.core_ack), 32'd0);
    check("midrst_rdata", 32'(bus.core_rdata), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_mem_wrEn", 32'(bus.mem_wrEn), 32'd0);
    settle(5);
    check("midrst_no_ack", 32'(n_ack - a0), 32'd0);
    model_ptr = 0;
    last_rd = '0;

    // Continuous round robin from ptr 0: 0,1,2,3,0,1,2,3.
    clear_ops();
    for (int c = 0; c < N; c++)
      repeat (2) add_op(c, 1'b1, AW'(12'h100 + c), DW'($urandom_range(0, 4095)));
    drive(-1); settle(2);

    // Randomised mixes over a small address window to hit read-after-write.
    for (int it = 0; it < 12; it++) begin
      clear_ops();
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 1) == 1)
          repeat ($urandom_range(1, 3))
            add_op(c, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                   DW'($urandom_range(0, 4095)));
      if (cnt[0] + cnt[1] + cnt[2] + cnt[3] == 0)
        add_op(it % N, 1'b0, AW'($urandom_range(0, 15)), 12'h000);
      drive(-1); settle(2);
    end

    settle(4);
    check("ack_queue_drained", 32'(ack_q.size()), 32'd0);
    check("write_queue_drained", 32'(wr_q.size()), 32'd0);
    check("final_busy", 32'(bus.busy), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
